fir_trig_sequencer: RTL and testbench

Acquisition controller for the four-channel FIR trigger datapath.
- Watches the per-channel time-over-threshold bits under a channel mask.
- On a qualified trigger, opens a fixed-length capture window for the downstream waveform/Q buffer and holds the baseline-sum pause override high for that window.
- Waits for a readout handshake, then enforces a holdoff before re-arming.
- Sits between the fir_trig outputs and the capture/readout logic; all signals are on the 60 MHz system clock.

---
 rtl/fir_trig_pkg.sv | 16 +
 rtl/sat_counter.sv | 18 +
 rtl/fir_trig_sequencer.sv | 147 ++++++++++++++
 tb/tb_fir_trig_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_trig_pkg.sv
// Shared state encoding and default widths for the FIR trigger acquisition sequencer.
// Definitions only: no latency, no flow control.
package fir_trig_pkg;
   localparam int NCH     = 4;
   localparam int WIN_W   = 12;
   localparam int CNT_W   = 16;
   localparam int COINC_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      CAPTURE,
      READOUT,
      HOLDOFF
   } seq_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all ones instead of wrapping.
// Increment is visible one cycle after inc; no backpressure.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end
endmodule

// File: rtl/fir_trig_sequencer.sv
// Acquisition sequencer: tot rising edge -> capture window -> readout handshake -> holdoff.
// All outputs registered one cycle after the sampling edge; rd_req is held until rd_ack.
// Build option FIR_TRIG_SEQUENCER_COINC_EN adds coinc_n, a minimum masked-channel coincidence.
module fir_trig_sequencer #(
   parameter int WIN_W = fir_trig_pkg::WIN_W,
   parameter int CNT_W = fir_trig_pkg::CNT_W,
   parameter int NCH   = fir_trig_pkg::NCH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             arm,
   input  logic [NCH-1:0]   ch_mask,
   input  logic [NCH-1:0]   tot_in,
   input  logic             fvalid_in,
   input  logic [WIN_W-1:0] win_len,
   input  logic [WIN_W-1:0] holdoff_len,
   input  logic             rd_ack,
`ifdef FIR_TRIG_SEQUENCER_COINC_EN
   input  logic [fir_trig_pkg::COINC_W-1:0] coinc_n,
`endif
   output logic             capture_en,
   output logic             pause_override,
   output logic             trig_stb,
   output logic [NCH-1:0]   trig_pattern,
   output logic             rd_req,
   output logic             busy,
   output logic [CNT_W-1:0] trig_count,
   output logic [CNT_W-1:0] lost_count
);
   import fir_trig_pkg::*;

   seq_state_t       state, state_nxt;
   logic [WIN_W-1:0] cnt, cnt_nxt;
   logic [NCH-1:0]   tot_prev, hit, rise;
   logic             qual, accept, lost_inc, capture_nxt, rd_req_nxt;

   assign hit  = tot_in & ch_mask;
   assign rise = hit & ~tot_prev;

`ifdef FIR_TRIG_SEQUENCER_COINC_EN
   logic [COINC_W-1:0] nhit, need;

   always_comb begin
      nhit = '0;
      for (int i = 0; i < NCH; i++) begin
         nhit = nhit + COINC_W'(hit[i]);
      end
   end

   assign need = (coinc_n == '0) ? COINC_W'(1) : coinc_n;
   assign qual = fvalid_in & (|rise) & (nhit >= need);
`else
   assign qual = fvalid_in & (|rise);
`endif

   assign busy = (state != IDLE) && (state != ARMED);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      capture_nxt = 1'b0;
      rd_req_nxt  = 1'b0;
      accept      = 1'b0;
      lost_inc    = 1'b0;
      case (state)
         IDLE: begin
            if (arm) state_nxt = ARMED;
         end
         ARMED: begin
            if (!arm) begin
               state_nxt = IDLE;
            end else if (qual) begin
               accept    = 1'b1;
               state_nxt = CAPTURE;
               cnt_nxt   = (win_len == '0) ? WIN_W'(1) : win_len;
            end
         end
         // First CAPTURE cycle carries trig_stb; the window opens one cycle later.
         CAPTURE: begin
            lost_inc = qual;
            if (cnt == '0) begin
               state_nxt  = READOUT;
               rd_req_nxt = 1'b1;
            end else begin
               capture_nxt = 1'b1;
               cnt_nxt     = cnt - WIN_W'(1);
            end
         end
         READOUT: begin
            lost_inc = qual;
            if (!rd_ack) begin
               rd_req_nxt = 1'b1;
            end else if (holdoff_len == '0) begin
               state_nxt = arm ? ARMED : IDLE;
            end else begin
               state_nxt = HOLDOFF;
               cnt_nxt   = holdoff_len;
            end
         end
         HOLDOFF: begin
            lost_inc = qual;
            if (cnt <= WIN_W'(1)) begin
               state_nxt = arm ? ARMED : IDLE;
            end else begin
               cnt_nxt = cnt - WIN_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         cnt            <= '0;
         tot_prev       <= '0;
         capture_en     <= 1'b0;
         pause_override <= 1'b0;
         trig_stb       <= 1'b0;
         trig_pattern   <= '0;
         rd_req         <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         tot_prev       <= tot_in;
         capture_en     <= capture_nxt;
         pause_override <= capture_nxt;
         trig_stb       <= accept;
         rd_req         <= rd_req_nxt;
         if (accept) trig_pattern <= hit;
      end
   end

   sat_counter #(.W(CNT_W)) u_trig_cnt (
      .clk   (clk),
      .rst_n (reset_n),
      .inc   (accept),
      .cnt   (trig_count)
   );

   sat_counter #(.W(CNT_W)) u_lost_cnt (
      .clk   (clk),
      .rst_n (reset_n),
      .inc   (lost_inc),
      .cnt   (lost_count)
   );
endmodule

// File: tb/tb_fir_trig_sequencer.sv
// Bench for fir_trig_sequencer: timestamp-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fir_trig_sequencer;
   logic        clk;
   logic        reset_n;
   logic        arm;
   logic [3:0]  ch_mask;
   logic [3:0]  tot_in;
   logic        fvalid_in;
   logic [11:0] win_len;
   logic [11:0] holdoff_len;
   logic        rd_ack;
`ifdef FIR_TRIG_SEQUENCER_COINC_EN
   logic [2:0]  coinc_n;
`endif
   logic        capture_en, pause_override, trig_stb, rd_req, busy;
   logic [3:0]  trig_pattern;
   logic [15:0] trig_count, lost_count;
   logic        sc_inc;
   logic [2:0]  sc_cnt;

   fir_trig_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .arm            (arm),
      .ch_mask        (ch_mask),
      .tot_in         (tot_in),
      .fvalid_in      (fvalid_in),
      .win_len        (win_len),
      .holdoff_len    (holdoff_len),
      .rd_ack         (rd_ack),
`ifdef FIR_TRIG_SEQUENCER_COINC_EN
      .coinc_n        (coinc_n),
`endif
      .capture_en     (capture_en),
      .pause_override (pause_override),
      .trig_stb       (trig_stb),
      .trig_pattern   (trig_pattern),
      .rd_req         (rd_req),
      .busy           (busy),
      .trig_count     (trig_count),
      .lost_count     (lost_count)
   );

   // Narrow instance so saturation is reachable in a few cycles.
   sat_counter #(.W(3)) u_sc (
      .clk   (clk),
      .rst_n (reset_n),
      .inc   (sc_inc),
      .cnt   (sc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model. Edge m_e samples inputs; "cycle m_e" is the interval after it.
   // An event is accepted at edge acc: strobe in cycle acc, window in acc+1..acc+n,
   // readout request from acc+n+1 until the edge that sees rd_ack (ack), busy until ack+hold.
   int         m_e, m_acc, m_n, m_ack, m_hold, m_tc, m_lc;
   bit         m_active, m_armed;
   logic [3:0] m_prev, m_pat;
   bit         x_stb, x_cap, x_rdq, x_busy;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_e = 0; m_acc = 0; m_n = 0; m_ack = -1; m_hold = 0; m_tc = 0; m_lc = 0;
         m_active = 1'b0; m_armed = 1'b0; m_prev = 4'h0; m_pat = 4'h0;
         x_stb = 1'b0; x_cap = 1'b0; x_rdq = 1'b0; x_busy = 1'b0;
      end else begin
         logic [3:0] hit;
         bit         q;
         m_e++;
         hit = tot_in & ch_mask;
         q   = fvalid_in && ((hit & ~m_prev) != 4'h0);
`ifdef FIR_TRIG_SEQUENCER_COINC_EN
         q   = q && ($countones(hit) >= ((coinc_n == 3'd0) ? 1 : int'(coinc_n)));
`endif
         m_prev = tot_in;
         if (m_active && q) m_lc = (m_lc < 65535) ? m_lc + 1 : m_lc;
         if (!m_active) begin
            if (m_armed && arm && q) begin
               m_active = 1'b1;
               m_acc    = m_e;
               m_n      = (win_len == 12'd0) ? 1 : int'(win_len);
               m_ack    = -1;
               m_pat    = hit;
               m_tc     = (m_tc < 65535) ? m_tc + 1 : m_tc;
            end else begin
               m_armed = arm;
            end
         end else if (m_ack < 0 && rd_ack && (m_e - 1 >= m_acc + m_n + 1)) begin
            m_ack  = m_e;
            m_hold = int'(holdoff_len);
         end
         if (m_active && m_ack >= 0 && m_e >= m_ack + m_hold) begin
            m_active = 1'b0;
            m_armed  = arm;
         end
         x_stb  = m_active && (m_e == m_acc);
         x_cap  = m_active && (m_e >= m_acc + 1) && (m_e <= m_acc + m_n);
         x_rdq  = m_active && (m_ack < 0) && (m_e >= m_acc + m_n + 1);
         x_busy = m_active;
      end
   end

   always @(negedge clk) begin
      if (chk_en && reset_n) begin
         chk("trig_stb",       32'(trig_stb),       32'(x_stb));
         chk("capture_en",     32'(capture_en),     32'(x_cap));
         chk("pause_override", 32'(pause_override), 32'(x_cap));
         chk("rd_req",         32'(rd_req),         32'(x_rdq));
         chk("busy",           32'(busy),           32'(x_busy));
         chk("trig_pattern",   32'(trig_pattern),   32'(m_pat));
         chk("trig_count",     32'(trig_count),     32'(m_tc));
         chk("lost_count",     32'(lost_count),     32'(m_lc));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #1;
      chk({tag, "_ctrl"}, 32'({capture_en, pause_override, trig_stb, rd_req, busy, trig_pattern}), 32'd0);
      chk({tag, "_cnts"}, {trig_count, lost_count}, 32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   task automatic go_armed(input logic [3:0] mask, input logic [11:0] wl, input logic [11:0] hl);
      arm = 1'b1; fvalid_in = 1'b1; ch_mask = mask; win_len = wl; holdoff_len = hl;
      tot_in = 4'h0; rd_ack = 1'b0;
      step();
      step();
   endtask

   initial begin
      int ncap, nstb, nb;
      reset_n = 1'b1; arm = 1'b0; ch_mask = 4'h0; tot_in = 4'h0; fvalid_in = 1'b0;
      win_len = 12'd0; holdoff_len = 12'd0; rd_ack = 1'b0; sc_inc = 1'b0;
`ifdef FIR_TRIG_SEQUENCER_COINC_EN
      coinc_n = 3'd0;
`endif
      #3;
      do_reset("rst0");
      chk_en = 1'b1;

      // Single-channel trigger, 5-cycle window, readout, 3-cycle holdoff.
      go_armed(4'b0010, 12'd5, 12'd3);
      tot_in = 4'b0010;
      step();
      chk("t1_stb", 32'(trig_stb), 32'd1);
      chk("t1_pat", 32'(trig_pattern), 32'h2);
      chk("t1_tc", 32'(trig_count), 32'd1);
      chk("t1_cap_first", 32'(capture_en), 32'd0);
      chk("t1_model_tc", 32'(m_tc), 32'd1);
      tot_in = 4'h0; ncap = 0; nstb = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (capture_en && pause_override) ncap++;
         if (trig_stb) nstb++;
      end
      chk("t1_window", 32'(ncap), 32'd5);
      chk("t1_stb_once", 32'(nstb), 32'd0);
      chk("t1_rdreq", 32'(rd_req), 32'd1);
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      chk("t1_rdreq_drop", 32'(rd_req), 32'd0);
      chk("t1_hold_busy", 32'(busy), 32'd1);
      step(); step(); step();
      chk("t1_hold_done", 32'(busy), 32'd0);

      // Masked-off channel and invalid filter output must not trigger.
      do_reset("t2_rst");
      go_armed(4'b0010, 12'd3, 12'd0);
      tot_in = 4'b0001; step();
      tot_in = 4'h0; step();
      ch_mask = 4'b0001; fvalid_in = 1'b0;
      tot_in = 4'b0001; step();
      tot_in = 4'h0; step();
      fvalid_in = 1'b1; step();
      chk("t2_no_trig", 32'(trig_count), 32'd0);
      chk("t2_idle", 32'(busy), 32'd0);
      tot_in = 4'b0001; step();
      chk("t2_pos_ctrl", 32'(trig_stb), 32'd1);

      // Lost triggers during capture and holdoff; re-arm after 10 holdoff cycles.
      do_reset("t3_rst");
      go_armed(4'b0110, 12'd6, 12'd10);
      tot_in = 4'b0010; step();
      tot_in = 4'h0; step();
      tot_in = 4'b0100; step();
      tot_in = 4'h0;
      for (int i = 0; i < 5; i++) step();
      chk("t3_rdreq", 32'(rd_req), 32'd1);
      rd_ack = 1'b1; step(); rd_ack = 1'b0;
      nb = int'(busy);
      for (int i = 0; i < 12; i++) begin
         tot_in = (i == 0) ? 4'b0100 : 4'h0;
         step();
         nb += int'(busy);
      end
      chk("t3_hold_len", 32'(nb), 32'd10);
      chk("t3_lost", 32'(lost_count), 32'd2);
      chk("t3_tc", 32'(trig_count), 32'd1);
      tot_in = 4'b0010; step();
      chk("t3_rearm", 32'(trig_stb), 32'd1);

      // Zero window and zero holdoff.
      do_reset("t4_rst");
      go_armed(4'b1111, 12'd0, 12'd0);
      tot_in = 4'b0001; step();
      tot_in = 4'h0; ncap = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (capture_en) ncap++;
      end
      chk("t4_window", 32'(ncap), 32'd1);
      chk("t4_rdreq", 32'(rd_req), 32'd1);
      rd_ack = 1'b1; step(); rd_ack = 1'b0;
      chk("t4_armed", 32'(busy), 32'd0);
      tot_in = 4'b0001; step();
      chk("t4_retrig", 32'(trig_stb), 32'd1);

      // Counter saturation and asynchronous reset mid-capture.
      do_reset("t5_rst0");
      tot_in = 4'h0;
      sc_inc = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("t5_sc_mid", 32'(sc_cnt), 32'd3);
      for (int i = 0; i < 7; i++) step();
      chk("t5_sc_sat", 32'(sc_cnt), 32'd7);
      sc_inc = 1'b0;
      go_armed(4'b1111, 12'd8, 12'd2);
      tot_in = 4'b0100; step();
      tot_in = 4'h0; step(); step();
      chk("t5_cap", 32'(capture_en), 32'd1);
      do_reset("t5_rst");

`ifdef FIR_TRIG_SEQUENCER_COINC_EN
      // Coincidence of two masked channels.
      coinc_n = 3'd2;
      go_armed(4'b1111, 12'd2, 12'd0);
      tot_in = 4'b0001; step();
      chk("t6_single", 32'(trig_stb), 32'd0);
      tot_in = 4'b1001; step();
      chk("t6_coinc", 32'(trig_stb), 32'd1);
      chk("t6_pat", 32'(trig_pattern), 32'h9);
      coinc_n = 3'd0;
      do_reset("t6_rst");
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) do_reset("rnd_rst");
         arm       = ($urandom_range(0, 7) != 0);
         fvalid_in = ($urandom_range(0, 5) != 0);
         tot_in    = 4'($urandom_range(0, 15));
         rd_ack    = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 15) == 0) ch_mask = 4'($urandom_range(0, 15));
         win_len     = 12'($urandom_range(0, 6));
         holdoff_len = 12'($urandom_range(0, 6));
         if ($urandom_range(0, 9) == 0) win_len = 12'($urandom_range(7, 40));
         if ($urandom_range(0, 9) == 0) holdoff_len = 12'($urandom_range(7, 40));
`ifdef FIR_TRIG_SEQUENCER_COINC_EN
         coinc_n = 3'($urandom_range(0, 4));
`endif
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
